// File: rtl/fir_pkg.sv
// Shared types and sizes for the FIR sequencer slice.
package fir_pkg;
    localparam int DW      = 17;
    localparam int YW      = 36;
    localparam int TAPS    = 4;
    localparam int FIR_LAT = 1;
    localparam int LEN_W   = 8;

    typedef logic [DW-1:0] coef_t [TAPS];

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;
endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Sample input stream and tagged output stream of the FIR sequencer.
interface fir_seq_ctrl_if;
    import fir_pkg::*;

    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [YW-1:0] m_data;
    logic          m_last;

    modport master (output s_valid, s_data, input s_ready, m_valid, m_data, m_last);
    modport slave  (input s_valid, s_data, output s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient registers; busy-time commits are deferred to frame end.
module fir_coef_bank
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic          cfg_commit,
    input  logic          idle,
    input  logic          frame_end,
    output coef_t         active
);
    coef_t shadow_r;
    coef_t active_r;
    logic  commit_pending_r;

    // Shadow bank write port, usable in any state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_r <= '{default: '0};
        end else if (cfg_we) begin
            shadow_r[cfg_addr] <= cfg_data;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Active bank copy; a commit seen during DONE rides along with the deferred copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_r         <= '{default: '0};
            commit_pending_r <= 1'b0;
        end else if (idle && cfg_commit) begin
            active_r         <= shadow_r;
            commit_pending_r <= 1'b0;
        end else if (frame_end && (commit_pending_r || cfg_commit)) begin
            active_r         <= shadow_r;
            commit_pending_r <= 1'b0;
        end else if (cfg_commit) begin
            commit_pending_r <= 1'b1;
        end else begin
            commit_pending_r <= commit_pending_r;
        end
    end

    assign active = active_r;
endmodule

// File: rtl/fir_seq_ctrl.sv
// Frame sequencer for the 4-tap FIR: sample intake, zero flush, output tagging.
module fir_seq_ctrl
    import fir_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [DW-1:0]    cfg_data,
    input  logic             cfg_commit,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    fir_seq_ctrl_if.slave    sif,
    output logic [DW-1:0]    x_in,
    output logic [DW-1:0]    c0,
    output logic [DW-1:0]    c1,
    output logic [DW-1:0]    c2,
    output logic [DW-1:0]    c3,
    input  logic [YW-1:0]    y_in,
    output logic             busy,
    output logic             done,
    output logic             underrun
);
    state_t           state_r, state_s;
    logic [LEN_W-1:0] len_r, cnt_r, cnt_s;
    logic [DW-1:0]    x_r, x_s;
    tag_t             tag_s;
    tag_t             tag_r [FIR_LAT+1];
    logic             m_valid_r, m_last_r;
    logic [YW-1:0]    m_data_r;
    logic             s_ready_r, busy_r, done_r, underrun_r, underrun_s;
    coef_t            coef_s;

    fir_coef_bank u_coef (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .idle       (state_r == ST_IDLE),
        .frame_end  (state_r == ST_DONE),
        .active     (coef_s)
    );

    // Next state, next sample and the tag generated for this cycle.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        x_s        = '0;
        tag_s      = '0;
        underrun_s = underrun_r;
        case (state_r)
            ST_IDLE: begin
                if (start && (frame_len != '0)) begin
                    state_s    = ST_RUN;
                    cnt_s      = '0;
                    underrun_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // No FIR enable: a missing sample becomes a zero sample.
                x_s         = sif.s_valid ? sif.s_data : '0;
                tag_s.valid = 1'b1;
                if (!sif.s_valid) begin
                    underrun_s = 1'b1;
                end else begin
                    underrun_s = underrun_r;
                end
                if (cnt_r == len_r - LEN_W'(1)) begin
                    state_s = ST_FLUSH;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + LEN_W'(1);
                end
            end
            ST_FLUSH: begin
                tag_s.valid = 1'b1;
                if (cnt_r == LEN_W'(TAPS - 2)) begin
                    tag_s.last = 1'b1;
                    state_s    = ST_DRAIN;
                    cnt_s      = '0;
                end else begin
                    cnt_s = cnt_r + LEN_W'(1);
                end
            end
            ST_DRAIN: begin
                if (m_last_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            len_r      <= '0;
            cnt_r      <= '0;
            x_r        <= '0;
            underrun_r <= 1'b0;
            s_ready_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            x_r        <= x_s;
            underrun_r <= underrun_s;
            s_ready_r  <= (state_s == ST_RUN);
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= (state_s == ST_DONE);
            if ((state_r == ST_IDLE) && (state_s == ST_RUN)) begin
                len_r <= frame_len;
            end else begin
                len_r <= len_r;
            end
        end
    end

    // Tag delay matches x_in register plus FIR latency; m_* register y_in alongside.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_r     <= '{default: '0};
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= '0;
        end else begin
            tag_r[0] <= tag_s;
            for (int i = 1; i <= FIR_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
            m_valid_r <= tag_r[FIR_LAT].valid;
            m_last_r  <= tag_r[FIR_LAT].last;
            m_data_r  <= y_in;
        end
    end

    assign sif.s_ready = s_ready_r;
    assign sif.m_valid = m_valid_r;
    assign sif.m_last  = m_last_r;
    assign sif.m_data  = m_data_r;
    assign x_in        = x_r;
    assign c0          = coef_s[0];
    assign c1          = coef_s[1];
    assign c2          = coef_s[2];
    assign c3          = coef_s[3];
    assign busy        = busy_r;
    assign done        = done_r;
    assign underrun    = underrun_r;
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed plus randomized bench for fir_seq_ctrl with a behavioural FIR and convolution model.
module tb_fir_seq_ctrl;
    import fir_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_we, cfg_commit, start;
    logic [1:0]       cfg_addr;
    logic [DW-1:0]    cfg_data;
    logic [LEN_W-1:0] frame_len;
    logic [DW-1:0]    x_in, c0, c1, c2, c3;
    logic [YW-1:0]    y_in;
    logic             busy, done, underrun;

    fir_seq_ctrl_if sif ();

    fir_seq_ctrl dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .start(start), .frame_len(frame_len), .sif(sif),
        .x_in(x_in), .c0(c0), .c1(c1), .c2(c2), .c3(c3), .y_in(y_in),
        .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_cyc = 0;
    int done_cnt = 0;
    logic [YW-1:0] beat_q [$];
    logic          lastf_q [$];
    logic [DW-1:0] exp_shadow [4];
    logic [DW-1:0] exp_coef [4];
    logic [DW-1:0] smp [256];
    logic [DW-1:0] xh [3];

    always @(posedge clk) cyc <= cyc + 1;

    // Environment FIR: one-clock registered 4-tap convolution of x_in.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_in <= '0;
            xh[0] <= '0; xh[1] <= '0; xh[2] <= '0;
        end else begin
            y_in <= YW'(c0) * YW'(x_in) + YW'(c1) * YW'(xh[0]) + YW'(c2) * YW'(xh[1]) + YW'(c3) * YW'(xh[2]);
            xh[0] <= x_in; xh[1] <= xh[0]; xh[2] <= xh[1];
        end
    end

    // Output beat collector.
    always @(negedge clk) begin
        if (sif.m_valid) begin
            beat_q.push_back(sif.m_data);
            lastf_q.push_back(sif.m_last);
            if (sif.m_last) last_cyc = cyc;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_coefs(input string tag);
        check({tag, "_c0"}, 64'(c0), 64'(exp_coef[0]));
        check({tag, "_c1"}, 64'(c1), 64'(exp_coef[1]));
        check({tag, "_c2"}, 64'(c2), 64'(exp_coef[2]));
        check({tag, "_c3"}, 64'(c3), 64'(exp_coef[3]));
    endtask

    task automatic cfg_write(input int a, input logic [DW-1:0] v);
        cfg_we = 1'b1; cfg_addr = a[1:0]; cfg_data = v;
        @(negedge clk);
        cfg_we = 1'b0;
        exp_shadow[a] = v;
    endtask

    task automatic commit_idle(input string tag);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        exp_coef = exp_shadow;
        check_coefs(tag);
    endtask

    task automatic run_frame(input int len, input int gap, input bit mid_cfg, input bit mid_start);
        logic [DW-1:0] xs [$];
        logic [YW-1:0] acc;
        beat_q.delete(); lastf_q.delete();
        start = 1'b1; frame_len = len[LEN_W-1:0];
        @(negedge clk);
        start = 1'b0;
        check("run_busy", 64'(busy), 64'd1);
        check("run_ready", 64'(sif.s_ready), 64'd1);
        check("underrun_clr", 64'(underrun), 64'd0);
        for (int i = 0; i < len; i++) begin
            sif.s_valid = (i != gap);
            sif.s_data  = smp[i];
            xs.push_back((i != gap) ? smp[i] : '0);
            cfg_we     = mid_cfg && (i < 4);
            cfg_addr   = 2'(i);
            cfg_data   = 17'd5;
            if (mid_cfg && (i < 4)) exp_shadow[i] = 17'd5;
            cfg_commit = mid_cfg && (i == 4);
            start      = mid_start && (i == 1);
            frame_len  = 8'd3;
            @(negedge clk);
            check("x_in_run", 64'(x_in), 64'(xs[i]));
            if (mid_cfg) check("c0_hold", 64'(c0), 64'(exp_coef[0]));
        end
        sif.s_valid = 1'b0; sif.s_data = '0; cfg_we = 1'b0; cfg_commit = 1'b0; start = 1'b0;
        for (int k = 0; k < TAPS - 1; k++) begin
            xs.push_back('0);
            @(negedge clk);
            check("x_in_flush", 64'(x_in), 64'd0);
            check("ready_flush", 64'(sif.s_ready), 64'd0);
        end
        for (int t = 0; t < 16 && done !== 1'b1; t++) @(negedge clk);
        check("done_seen", 64'(done), 64'd1);
        check("done_after_last", 64'(cyc - last_cyc), 64'd1);
        check_coefs("coef_frame");
        check("beat_count", 64'(beat_q.size()), 64'(len + TAPS - 1));
        for (int n = 0; n < len + TAPS - 1 && n < beat_q.size(); n++) begin
            acc = '0;
            for (int k = 0; k < TAPS; k++)
                if (n - k >= 0) acc += YW'(exp_coef[k]) * YW'(xs[n-k]);
            check("m_data", 64'(beat_q[n]), 64'(acc));
            check("m_last", 64'(lastf_q[n]), 64'(n == len + TAPS - 2));
        end
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("underrun_end", 64'(underrun), 64'(gap >= 0 && gap < len));
        if (mid_cfg) begin
            exp_coef = exp_shadow;
            check_coefs("commit_pend");
        end
    endtask

    initial begin
        int d0;
        reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        start = 1'b0; frame_len = '0; sif.s_valid = 1'b0; sif.s_data = '0;
        for (int a = 0; a < 4; a++) begin exp_shadow[a] = '0; exp_coef[a] = '0; end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_x_in", 64'(x_in), 64'd0);
        check("rst_ready", 64'(sif.s_ready), 64'd0);
        check("rst_m_valid", 64'(sif.m_valid), 64'd0);
        check("rst_m_data", 64'(sif.m_data), 64'd0);
        check("rst_m_last", 64'(sif.m_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        check_coefs("rst");

        for (int a = 0; a < 4; a++) cfg_write(a, 17'(a));
        check_coefs("pre_commit");
        commit_idle("commit_idle");

        // Same-cycle write and commit copies the old shadow.
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 17'd7; cfg_commit = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; cfg_commit = 1'b0;
        exp_coef = exp_shadow;
        exp_shadow[1] = 17'd7;
        check_coefs("we_commit_same");
        commit_idle("commit_new");
        cfg_write(1, 17'd1);
        commit_idle("commit_restore");
        repeat (3) @(negedge clk);

        smp[0] = 17'd3; smp[1] = 17'd2; smp[2] = 17'd1; smp[3] = 17'd0;
        smp[4] = 17'd1; smp[5] = 17'd2; smp[6] = 17'd3;
        run_frame(7, -1, 1'b0, 1'b0);
        run_frame(7, 2, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("underrun_sticky", 64'(underrun), 64'd1);

        start = 1'b1; frame_len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("zero_len_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("zero_len_ready", 64'(sif.s_ready), 64'd0);
        check("zero_len_urun", 64'(underrun), 64'd1);

        smp[7] = 17'd4;
        run_frame(8, -1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        for (int f = 0; f < 6; f++) begin
            int len, gap;
            for (int a = 0; a < 4; a++) cfg_write(a, 17'($urandom_range(0, 17'h1FFFF)));
            commit_idle("commit_rand");
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) smp[i] = 17'($urandom_range(0, 17'h1FFFF));
            gap = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
            run_frame(len, gap, 1'b0, f[0]);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Reset during FLUSH aborts the frame without a done pulse.
        d0 = done_cnt;
        start = 1'b1; frame_len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sif.s_valid = 1'b1; sif.s_data = 17'($urandom_range(1, 255));
            @(negedge clk);
        end
        sif.s_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        beat_q.delete();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_m_valid", 64'(sif.m_valid), 64'd0);
        check("midrst_x_in", 64'(x_in), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt), 64'(d0));
        check("midrst_no_beats", 64'(beat_q.size()), 64'd0);
        check("midrst_idle", 64'(busy), 64'd0);
        for (int a = 0; a < 4; a++) exp_coef[a] = '0;
        check_coefs("midrst_coef");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
- Sequences the 4-tap FIR datapath (`fir`) for one frame at a time.
- Owns the coefficient registers: shadow bank written over a config port, active bank driven to c0..c3.
- Accepts input samples over a valid/ready stream and drives x_in every clock.
- Appends TAPS-1 zero flush samples so the full convolution tail is produced.
- Tags the FIR output y_out with valid/last, aligned to the FIR pipeline latency.

Parameters:
- DW, 17, sample and coefficient width (x_in, c0..c3).
- YW, 36, FIR output width.
- TAPS, 4, number of FIR taps; flush length is TAPS-1.
- FIR_LAT, 1, clocks from x_in change to the corresponding y_out.
- LEN_W, 8, frame-length counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_we  in  1  shadow coefficient write strobe.
- cfg_addr  in  2  tap index 0..3.
- cfg_data  in  DW  coefficient value.
- cfg_commit  in  1  request shadow->active copy.
- start  in  1  begin frame (pulse).
- frame_len  in  LEN_W  samples in frame, sampled on start.
- s_valid  in  1  input sample valid.
- s_data  in  DW  input sample.
- s_ready  out  1  controller accepting samples.
- x_in  out  DW  to FIR x_in.
- c0,c1,c2,c3  out  DW  active coefficients to FIR.
- y_in  in  YW  from FIR y_out.
- m_valid  out  1  m_data holds a frame output.
- m_data  out  YW  registered copy of y_in.
- m_last  out  1  final output of frame.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at frame end.
- underrun  out  1  sticky: s_valid low during RUN.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0; shadow and active coefficients 0.
  - Counters, commit_pending, underrun and the tag pipeline 0.
- States: IDLE, RUN, FLUSH, DRAIN, DONE.
- IDLE:
  - x_in=0, s_ready=0.
  - start=1 with frame_len!=0: latch len, cnt=0, go to RUN.
  - start with frame_len=0 is ignored. start outside IDLE is ignored.
- RUN:
  - s_ready=1.
  - Each clock: x_in <= s_valid ? s_data : 0, and cnt increments regardless.
  - s_valid=0 in RUN sets underrun. The FIR has no enable, so a bubble is a zero sample.
  - Entering RUN from IDLE clears underrun.
  - When cnt reaches len-1 on a transfer: go to FLUSH, cnt=0.
- FLUSH:
  - s_ready=0, x_in=0 for exactly TAPS-1 clocks, then go to DRAIN.
- Tag pipeline:
  - A shift register of depth FIR_LAT+1 carries a tag for every RUN/FLUSH cycle.
  - The tag's last bit is set on the final FLUSH cycle.
  - m_valid/m_last are the tag outputs; m_data <= y_in registered in the same clock.
  - Total m_valid beats per frame = len+TAPS-1, contiguous.
- DRAIN: wait until the m_last beat has been output, then go to DONE.
- DONE: done=1 for one clock, then go to IDLE.
- busy is 1 in every state except IDLE.
- Coefficients:
  - cfg_we writes shadow[cfg_addr] at any time.
  - cfg_commit in IDLE: active<=shadow on the next clock.
  - cfg_commit while busy sets commit_pending; the copy happens on the DONE->IDLE transition.
  - Active coefficients never change mid-frame.
  - cfg_we and cfg_commit in the same IDLE cycle: the commit copies the old shadow; the new value is committed on the next commit.
- No back-pressure on the m_* side; the consumer must always accept.
- Reset asserted mid-frame: immediate return to IDLE, outputs 0, pending commit discarded.
- Width rules: counters are LEN_W bits; frame_len max 2^LEN_W-1; no truncation of y_in.

Decomposition:
- Shared package fir_pkg:
  - state enum (IDLE, RUN, FLUSH, DRAIN, DONE).
  - DW, YW, TAPS localparams.
  - coefficient array typedef logic [DW-1:0] coef_t [TAPS].
- Sub-module fir_coef_bank: shadow/active registers, commit_pending logic.
- The FSM, counters and tag pipeline stay in fir_seq_ctrl.

Test Plan:
- Reset, then check outputs before any activity: all outputs 0, c0..c3=0, busy=0.
- Config shadow 0,1,2,3 and commit in IDLE: c0..c3=0,1,2,3 the next clock.
- Happy-path frame:
  - Stimulus: frame_len=7, gap-free stream 3,2,1,0,1,2,3.
  - x_in sequence: 3,2,1,0,1,2,3,0,0,0.
  - m_data: 10 beats 0,3,8,14,8,4,4,10,12,9.
  - m_last on the 10th beat; done one clock after; underrun=0.
- Underrun:
  - Stimulus: same frame with s_valid=0 on the 3rd cycle.
  - x_in gets 0 in that slot; underrun=1 sticky; still 10 beats.
  - underrun is cleared on the next start.
- Commit while busy:
  - Stimulus: write shadow 5,5,5,5 plus commit during RUN.
  - c0..c3 stay 0,1,2,3 until DONE, then become 5 in IDLE.
- Ignored starts and reset mid-frame:
  - start with frame_len=0: stays IDLE.
  - start during RUN: ignored.
  - reset low mid-FLUSH: busy=0, m_valid=0, no done pulse.
